// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin bus arbiter, one transaction per grant.
// Define BUS_ARBITER_TIMEOUT_EN to force-complete grants stalled longer than TIMEOUT cycles.
module bus_arbiter_2m #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_a_request,
   input  logic        i_a_rw,
   input  logic [31:0] i_a_address,
   input  logic [31:0] i_a_wdata,
   output logic [31:0] o_a_rdata,
   output logic        o_a_ready,
   input  logic        i_b_request,
   input  logic        i_b_rw,
   input  logic [31:0] i_b_address,
   input  logic [31:0] i_b_wdata,
   output logic [31:0] o_b_rdata,
   output logic        o_b_ready,
   output logic        o_bus_request,
   output logic        o_bus_rw,
   output logic [31:0] o_bus_address,
   output logic [31:0] o_bus_wdata,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_ready,
   output logic [1:0]  o_grant,
   output logic        o_timeout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT_A,
      S_GRANT_B,
      S_RELEASE
   } state_t;

   state_t r_state;
   state_t w_state_next;
   logic   r_last;        // 1 = master B owned the bus most recently
   logic   w_last_next;
   logic   w_granted;
   logic   w_own_b;
   logic   w_own_req;
   logic   w_expire;
   logic   w_done;

   assign w_granted = (r_state == S_GRANT_A) || (r_state == S_GRANT_B);
   assign w_own_b   = (r_state == S_RELEASE) ? r_last : (r_state == S_GRANT_B);
   assign w_own_req = w_own_b ? i_b_request : i_a_request;
   assign w_done    = i_bus_ready || w_expire;

`ifdef BUS_ARBITER_TIMEOUT_EN
   logic [15:0] r_wait;

   // Idle/release cycles clear the counter, so every new grant starts at zero.
   always_ff @(posedge i_clock) begin
      if (i_reset || !w_granted) begin
         r_wait <= '0;
      end else if (!i_bus_ready) begin
         r_wait <= r_wait + 16'd1;
      end
   end

   assign w_expire = w_granted && !i_bus_ready && (r_wait == 16'(TIMEOUT - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^32'(TIMEOUT);
   assign w_expire         = 1'b0;
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_last  <= w_last_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_last_next   = r_last;
      o_grant       = 2'b00;
      o_bus_request = 1'b0;
      o_bus_rw      = 1'b0;
      o_bus_address = '0;
      o_bus_wdata   = '0;
      o_a_rdata     = '0;
      o_a_ready     = 1'b0;
      o_b_rdata     = '0;
      o_b_ready     = 1'b0;
      o_timeout     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_a_request && i_b_request) begin
               w_state_next = r_last ? S_GRANT_A : S_GRANT_B;
            end else if (i_a_request) begin
               w_state_next = S_GRANT_A;
            end else if (i_b_request) begin
               w_state_next = S_GRANT_B;
            end
         end

         S_GRANT_A, S_GRANT_B: begin
            o_grant       = w_own_b ? 2'b10 : 2'b01;
            o_bus_request = w_own_req && !w_expire;
            o_bus_rw      = w_own_b ? i_b_rw      : i_a_rw;
            o_bus_address = w_own_b ? i_b_address : i_a_address;
            o_bus_wdata   = w_own_b ? i_b_wdata   : i_a_wdata;
            o_timeout     = w_expire;
            // A forced completion returns zero data rather than whatever the bus floats.
            if (w_own_b) begin
               o_b_ready = w_done;
               o_b_rdata = w_expire ? '0 : i_bus_rdata;
            end else begin
               o_a_ready = w_done;
               o_a_rdata = w_expire ? '0 : i_bus_rdata;
            end
            if (w_done) begin
               w_last_next  = w_own_b;
               w_state_next = S_RELEASE;
            end else if (!w_own_req) begin
               w_last_next  = w_own_b;
               w_state_next = S_IDLE;
            end
         end

         S_RELEASE: begin
            o_grant = r_last ? 2'b10 : 2'b01;
            if (!w_own_req) begin
               w_state_next = S_IDLE;
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Scoreboard bench for bus_arbiter_2m: directed master transactions, expected bus
// grants and master responses queued up front and checked by independent monitors.
module tb_bus_arbiter_2m;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_a_request, i_a_rw, i_b_request, i_b_rw;
   logic [31:0] i_a_address, i_a_wdata, i_b_address, i_b_wdata;
   logic [31:0] o_a_rdata, o_b_rdata;
   logic        o_a_ready, o_b_ready;
   logic        o_bus_request, o_bus_rw;
   logic [31:0] o_bus_address, o_bus_wdata;
   logic [31:0] i_bus_rdata;
   logic        i_bus_ready;
   logic [1:0]  o_grant;
   logic        o_timeout;

   always #5 i_clock = ~i_clock;

   bus_arbiter_2m #(.TIMEOUT(16)) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_a_request   (i_a_request),
      .i_a_rw        (i_a_rw),
      .i_a_address   (i_a_address),
      .i_a_wdata     (i_a_wdata),
      .o_a_rdata     (o_a_rdata),
      .o_a_ready     (o_a_ready),
      .i_b_request   (i_b_request),
      .i_b_rw        (i_b_rw),
      .i_b_address   (i_b_address),
      .i_b_wdata     (i_b_wdata),
      .o_b_rdata     (o_b_rdata),
      .o_b_ready     (o_b_ready),
      .o_bus_request (o_bus_request),
      .o_bus_rw      (o_bus_rw),
      .o_bus_address (o_bus_address),
      .o_bus_wdata   (o_bus_wdata),
      .i_bus_rdata   (i_bus_rdata),
      .i_bus_ready   (i_bus_ready),
      .o_grant       (o_grant),
      .o_timeout     (o_timeout)
   );

   typedef struct packed {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   typedef struct packed {
      logic [1:0]  grant;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   typedef struct packed {
      logic        b;
      logic [31:0] rdata;
      logic        to;
      logic [31:0] cyc;
   } rsp_t;

   txn_t q_a[$];
   txn_t q_b[$];
   bus_t q_bus[$];
   rsp_t q_rsp[$];

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic        mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: bound expired or unexpected event at t=%0t", name, $time);
   endtask

   function automatic txn_t mk(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
      txn_t t;
      t.rw = rw; t.addr = addr; t.wdata = wdata;
      return t;
   endfunction

   task automatic exp_bus(input logic [1:0] g, input logic rw, input logic [31:0] a, input logic [31:0] d);
      bus_t e;
      e.grant = g; e.rw = rw; e.addr = a; e.wdata = d;
      q_bus.push_back(e);
   endtask

   task automatic exp_rsp(input logic b, input logic [31:0] rdata, input logic to, input logic [31:0] cyc);
      rsp_t e;
      e.b = b; e.rdata = rdata; e.to = to; e.cyc = cyc;
      q_rsp.push_back(e);
   endtask

   task automatic set_master(input logic is_b, input logic req, input txn_t t);
      if (is_b) begin
         i_b_request = req; i_b_rw = t.rw; i_b_address = t.addr; i_b_wdata = t.wdata;
      end else begin
         i_a_request = req; i_a_rw = t.rw; i_a_address = t.addr; i_a_wdata = t.wdata;
      end
   endtask

   // Master agent: hold request until ready is seen, drop it the next cycle.
   task automatic agent(input logic is_b);
      txn_t        t;
      int unsigned n;
      logic        got;
      forever begin
         @(posedge i_clock); #1;
         if ((is_b && q_b.size() > 0) || (!is_b && q_a.size() > 0)) begin
            if (is_b) t = q_b.pop_front();
            else      t = q_a.pop_front();
            set_master(is_b, 1'b1, t);
            n = 0; got = 1'b0;
            while (!got && n < 300) begin
               @(negedge i_clock);
               got = is_b ? o_b_ready : o_a_ready;
               n++;
            end
            if (!got) fail_now(is_b ? "b_ready_wait" : "a_ready_wait");
            @(posedge i_clock); #1;
            set_master(is_b, 1'b0, '0);
         end
      end
   endtask

   initial agent(1'b0);
   initial agent(1'b1);

   function automatic int unsigned slave_lat(input logic [31:0] a);
      if (a == 32'h1000_0004) return 4;
      if (a == 32'h7FFF_FFF0 || a == 32'h1000_0008) return 32'hFFFF;
      return 0;
   endfunction

   function automatic logic [31:0] slave_data(input logic [31:0] a);
      return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : ~a;
   endfunction

   // Slave: answers after a per-address number of wait cycles, drives junk otherwise.
   initial begin
      int unsigned cnt;
      cnt = 0;
      i_bus_ready = 1'b0;
      i_bus_rdata = 32'hBADC_0DE0;
      forever begin
         @(posedge i_clock); #2;
         if (o_bus_request === 1'b1) begin
            if (cnt == slave_lat(o_bus_address)) begin
               i_bus_ready = 1'b1;
               i_bus_rdata = slave_data(o_bus_address);
            end else begin
               i_bus_ready = 1'b0;
               i_bus_rdata = 32'hBADC_0DE0;
            end
            cnt++;
         end else begin
            i_bus_ready = 1'b0;
            i_bus_rdata = 32'hBADC_0DE0;
            cnt = 0;
         end
      end
   end

   // Bus monitor: each rising o_bus_request pops the next expected grant; held values stay stable.
   initial begin
      bus_t cur, e;
      logic prev;
      prev = 1'b0;
      cur  = '0;
      forever begin
         @(negedge i_clock);
         if (mon_en) begin
            if (o_bus_request === 1'b1) begin
               if (!prev) begin
                  if (q_bus.size() == 0) begin
                     fail_now("bus_unexpected");
                     cur = {o_grant, o_bus_rw, o_bus_address, o_bus_wdata};
                  end else begin
                     e = q_bus.pop_front();
                     check("bus_grant", 32'(o_grant), 32'(e.grant));
                     check("bus_rw", 32'(o_bus_rw), 32'(e.rw));
                     check("bus_addr", o_bus_address, e.addr);
                     check("bus_wdata", o_bus_wdata, e.wdata);
                     cur = e;
                  end
               end else begin
                  check("bus_hold_grant", 32'(o_grant), 32'(cur.grant));
                  check("bus_hold_addr", o_bus_address, cur.addr);
                  check("bus_hold_wdata", o_bus_wdata, cur.wdata);
                  check("bus_hold_rw", 32'(o_bus_rw), 32'(cur.rw));
               end
               prev = 1'b1;
            end else begin
               prev = 1'b0;
               if (o_grant === 2'b00) begin
                  check("bus_idle_addr", o_bus_address, 32'h0);
                  check("bus_idle_wdata", o_bus_wdata, 32'h0);
               end
            end
         end
      end
   end

   // Response monitor: each ready pulse pops the next expected completion.
   initial begin
      rsp_t        e;
      int unsigned gcyc;
      gcyc = 0;
      forever begin
         @(negedge i_clock);
         if (mon_en) begin
            if (o_grant === 2'b00) gcyc = 0;
            else                   gcyc++;
            if (o_a_ready === 1'b1 || o_b_ready === 1'b1) begin
               if (q_rsp.size() == 0) begin
                  fail_now("rsp_unexpected");
               end else begin
                  e = q_rsp.pop_front();
                  check("rsp_a_ready", 32'(o_a_ready), 32'(!e.b));
                  check("rsp_b_ready", 32'(o_b_ready), 32'(e.b));
                  check("rsp_rdata", e.b ? o_b_rdata : o_a_rdata, e.rdata);
                  check("rsp_other_rdata", e.b ? o_a_rdata : o_b_rdata, 32'h0);
                  check("rsp_timeout", 32'(o_timeout), 32'(e.to));
                  check("rsp_grant_cycle", gcyc, e.cyc);
               end
            end else begin
               check("timeout_quiet", 32'(o_timeout), 32'h0);
            end
         end
      end
   end

   task automatic wait_idle(input string name);
      int unsigned n;
      logic        done;
      n = 0; done = 1'b0;
      while (!done && n < 400) begin
         @(negedge i_clock);
         done = (q_a.size() == 0) && (q_b.size() == 0) && (q_rsp.size() == 0) &&
                (q_bus.size() == 0) && !i_a_request && !i_b_request && (o_grant == 2'b00);
         n++;
      end
      if (!done) fail_now(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      i_reset = 1'b1;
      set_master(1'b0, 1'b0, '0);
      set_master(1'b1, 1'b0, '0);
      repeat (3) @(posedge i_clock);
      @(negedge i_clock);
      check("rst_grant", 32'(o_grant), 32'h0);
      check("rst_bus_request", 32'(o_bus_request), 32'h0);
      check("rst_bus_rw", 32'(o_bus_rw), 32'h0);
      check("rst_bus_addr", o_bus_address, 32'h0);
      check("rst_bus_wdata", o_bus_wdata, 32'h0);
      check("rst_a_ready", 32'(o_a_ready), 32'h0);
      check("rst_b_ready", 32'(o_b_ready), 32'h0);
      check("rst_a_rdata", o_a_rdata, 32'h0);
      check("rst_b_rdata", o_b_rdata, 32'h0);
      check("rst_timeout", 32'(o_timeout), 32'h0);
      @(posedge i_clock); #1;
      i_reset = 1'b0;
      mon_en  = 1'b1;

      // 1: single A read, one-cycle latency, release then idle
      @(negedge i_clock);
      exp_bus(2'b01, 1'b0, 32'h0000_0010, 32'h0);
      exp_rsp(1'b0, 32'hDEAD_BEEF, 1'b0, 32'd1);
      q_a.push_back(mk(1'b0, 32'h0000_0010, 32'h0));
      @(negedge i_clock);
      check("t1_req_cycle_n", 32'(o_bus_request), 32'h0);
      @(negedge i_clock);
      check("t1_req_cycle_n1", 32'(o_bus_request), 32'h1);
      check("t1_grant_a", 32'(o_grant), 32'h1);
      @(negedge i_clock);
      check("t1_release_grant", 32'(o_grant), 32'h1);
      check("t1_release_req", 32'(o_bus_request), 32'h0);
      @(negedge i_clock);
      check("t1_idle_grant", 32'(o_grant), 32'h0);
      wait_idle("t1_idle");

      // 2: simultaneous after reset, A wins the first tie
      @(posedge i_clock); #1; i_reset = 1'b1;
      @(posedge i_clock); #1; i_reset = 1'b0;
      @(negedge i_clock);
      exp_bus(2'b01, 1'b0, 32'h0001_0000, 32'h0);
      exp_bus(2'b10, 1'b0, 32'h1000_0000, 32'h0);
      exp_rsp(1'b0, 32'hFFFE_FFFF, 1'b0, 32'd1);
      exp_rsp(1'b1, 32'hEFFF_FFFF, 1'b0, 32'd1);
      q_a.push_back(mk(1'b0, 32'h0001_0000, 32'h0));
      q_b.push_back(mk(1'b0, 32'h1000_0000, 32'h0));
      wait_idle("t2_idle");

      // 3: A re-requests at once while B pends: order A, B, A
      @(negedge i_clock);
      exp_bus(2'b01, 1'b0, 32'h0000_0100, 32'h0);
      exp_bus(2'b10, 1'b0, 32'h0002_0000, 32'h0);
      exp_bus(2'b01, 1'b1, 32'h0000_0200, 32'h55AA_55AA);
      exp_rsp(1'b0, 32'hFFFF_FEFF, 1'b0, 32'd1);
      exp_rsp(1'b1, 32'hFFFD_FFFF, 1'b0, 32'd1);
      exp_rsp(1'b0, 32'hFFFF_FDFF, 1'b0, 32'd1);
      q_a.push_back(mk(1'b0, 32'h0000_0100, 32'h0));
      q_a.push_back(mk(1'b1, 32'h0000_0200, 32'h55AA_55AA));
      q_b.push_back(mk(1'b0, 32'h0002_0000, 32'h0));
      wait_idle("t3_idle");

      // 4: B write with 4 wait states (A last owner, so B wins the tie), then A
      @(negedge i_clock);
      exp_bus(2'b10, 1'b1, 32'h1000_0004, 32'h1234_5678);
      exp_bus(2'b01, 1'b0, 32'h0000_0010, 32'h0);
      exp_rsp(1'b1, 32'hEFFF_FFFB, 1'b0, 32'd5);
      exp_rsp(1'b0, 32'hDEAD_BEEF, 1'b0, 32'd1);
      q_b.push_back(mk(1'b1, 32'h1000_0004, 32'h1234_5678));
      q_a.push_back(mk(1'b0, 32'h0000_0010, 32'h0));
      wait_idle("t4_idle");

      // 5: reset while B waits on a stalled slave
      @(negedge i_clock);
      exp_bus(2'b10, 1'b1, 32'h1000_0008, 32'hCAFE_F00D);
      @(posedge i_clock); #1;
      set_master(1'b1, 1'b1, mk(1'b1, 32'h1000_0008, 32'hCAFE_F00D));
      n = 0;
      while (o_grant !== 2'b10 && n < 10) begin
         @(negedge i_clock);
         n++;
      end
      if (o_grant !== 2'b10) fail_now("t5_grant_b");
      @(negedge i_clock);
      @(posedge i_clock); #1; i_reset = 1'b1;
      @(posedge i_clock); #1; i_reset = 1'b0;
      set_master(1'b1, 1'b0, '0);
      @(negedge i_clock);
      check("t5_grant_after_rst", 32'(o_grant), 32'h0);
      check("t5_req_after_rst", 32'(o_bus_request), 32'h0);
      check("t5_addr_after_rst", o_bus_address, 32'h0);
      wait_idle("t5_idle");

      // 6: unmapped address, slave never answers
`ifdef BUS_ARBITER_TIMEOUT_EN
      @(negedge i_clock);
      exp_bus(2'b01, 1'b0, 32'h7FFF_FFF0, 32'h0);
      exp_rsp(1'b0, 32'h0, 1'b1, 32'd16);
      exp_bus(2'b01, 1'b0, 32'h0000_0010, 32'h0);
      exp_rsp(1'b0, 32'hDEAD_BEEF, 1'b0, 32'd1);
      q_a.push_back(mk(1'b0, 32'h7FFF_FFF0, 32'h0));
      q_a.push_back(mk(1'b0, 32'h0000_0010, 32'h0));
      wait_idle("t6_idle");
`else
      @(negedge i_clock);
      exp_bus(2'b01, 1'b0, 32'h7FFF_FFF0, 32'h0);
      @(posedge i_clock); #1;
      set_master(1'b0, 1'b1, mk(1'b0, 32'h7FFF_FFF0, 32'h0));
      repeat (101) @(negedge i_clock);
      check("t6_still_granted", 32'(o_grant), 32'h1);
      check("t6_still_requesting", 32'(o_bus_request), 32'h1);
      @(posedge i_clock); #1;
      set_master(1'b0, 1'b0, '0);
      @(negedge i_clock);
      check("t6_drop_req", 32'(o_bus_request), 32'h0);
      @(negedge i_clock);
      check("t6_drop_idle", 32'(o_grant), 32'h0);
      wait_idle("t6_idle");
`endif

      check("end_bus_queue", 32'(q_bus.size()), 32'h0);
      check("end_rsp_queue", 32'(q_rsp.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
